// File: rtl/tpg_hsubsample.sv
`default_nettype none
// ============================================================================
// Module   : tpg_hsubsample
// Brief    : AXI4-Lite programmed test pattern generator (colour bars, ramp)
//            followed by a 2:1 horizontal decimator, 24-bit AXI4-Stream out.
//            Optional feature macro: HSUB_AVG_EN (average pixel pairs).
// Revision : 1.0 - initial release
// ============================================================================
module tpg_hsubsample #(
    parameter int C_ADDR_W  = 6,
    parameter int C_MAX_DIM = 4096
) (
    input  logic                aclk_50MHz,
    input  logic                areset_0,
    input  logic [C_ADDR_W-1:0] s_axi_awaddr,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [C_ADDR_W-1:0] s_axi_araddr,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [23:0]         tdata,
    output logic                tvalid,
    input  logic                tready,
    output logic                tuser,
    output logic                tlast
);

    localparam logic [C_ADDR_W-1:0] C_ADDR_CTRL = C_ADDR_W'('h00);
    localparam logic [C_ADDR_W-1:0] C_ADDR_H    = C_ADDR_W'('h10);
    localparam logic [C_ADDR_W-1:0] C_ADDR_W_   = C_ADDR_W'('h18);
    localparam logic [C_ADDR_W-1:0] C_ADDR_PAT  = C_ADDR_W'('h20);
    localparam logic [31:0]         C_MAX       = 32'(C_MAX_DIM);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        w_start, w_dims_ok, w_last_beat;
    logic        r_awready, r_bvalid, r_arready, r_rvalid;
    logic        w_wr, w_rd;
    logic [31:0] r_rdata, w_rdata;
    logic        r_ap_start, r_ap_done, r_auto;
    logic [12:0] r_reg_h, r_reg_w;
    logic [7:0]  r_reg_pat;
    logic [12:0] r_h, r_w, r_x, r_y, r_bar_cnt, w_bw;
    logic [7:0]  r_pat;
    logic [2:0]  r_bar;
    logic        r_gen_busy, w_adv, w_x_last, w_bar_wrap, w_load;
    logic [23:0] w_pix, w_pair, r_hold;
    logic        r_tvalid, r_tuser, r_tlast, r_teof;
    logic [23:0] r_tdata;
    logic        w_unused;

    assign w_unused = ^{s_axi_wstrb, s_axi_wdata[31:13]};

    // ---------------- AXI4-Lite slave ----------------
    assign w_wr          = r_awready & s_axi_awvalid & s_axi_wvalid;
    assign w_rd          = r_arready & s_axi_arvalid;
    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_awready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = 2'b00;

    // Write and read channel handshakes, one transaction outstanding each
    always_ff @(posedge aclk_50MHz or posedge areset_0) begin
        if (areset_0) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            if (r_awready)
                r_awready <= 1'b0;
            else if (s_axi_awvalid && s_axi_wvalid && !r_bvalid)
                r_awready <= 1'b1;
            if (w_wr)
                r_bvalid <= 1'b1;
            else if (s_axi_bready)
                r_bvalid <= 1'b0;
            if (r_arready)
                r_arready <= 1'b0;
            else if (s_axi_arvalid && !r_rvalid)
                r_arready <= 1'b1;
            if (w_rd) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
            end else if (s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Register read mux; unmapped addresses read as zero
    always_comb begin
        w_rdata = 32'd0;
        case (s_axi_araddr)
            C_ADDR_CTRL: w_rdata = {24'd0, r_auto, 4'd0, (r_state == ST_IDLE), r_ap_done, r_ap_start};
            C_ADDR_H:    w_rdata = {19'd0, r_reg_h};
            C_ADDR_W_:   w_rdata = {19'd0, r_reg_w};
            C_ADDR_PAT:  w_rdata = {24'd0, r_reg_pat};
            default:     w_rdata = 32'd0;
        endcase
    end

    // Control/config registers; ap_start self-clears when a frame launches
    always_ff @(posedge aclk_50MHz or posedge areset_0) begin
        if (areset_0) begin
            r_ap_start <= 1'b0;
            r_ap_done  <= 1'b0;
            r_auto     <= 1'b0;
            r_reg_h    <= 13'd0;
            r_reg_w    <= 13'd0;
            r_reg_pat  <= 8'd0;
        end else begin
            if (w_wr && s_axi_awaddr == C_ADDR_CTRL) begin
                r_ap_start <= s_axi_wdata[0];
                r_auto     <= s_axi_wdata[7];
            end else if (w_start) begin
                r_ap_start <= 1'b0;
            end
            if (w_wr && s_axi_awaddr == C_ADDR_H)   r_reg_h   <= s_axi_wdata[12:0];
            if (w_wr && s_axi_awaddr == C_ADDR_W_)  r_reg_w   <= s_axi_wdata[12:0];
            if (w_wr && s_axi_awaddr == C_ADDR_PAT) r_reg_pat <= s_axi_wdata[7:0];
            if (r_state == ST_DONE)
                r_ap_done <= 1'b1;
            else if (w_rd && s_axi_araddr == C_ADDR_CTRL)
                r_ap_done <= 1'b0;
        end
    end

    // ---------------- Frame control FSM ----------------
    assign w_dims_ok   = (r_reg_h != 13'd0) && ({19'd0, r_reg_h} <= C_MAX) &&
                         (r_reg_w != 13'd0) && ({19'd0, r_reg_w} <= C_MAX);
    assign w_last_beat = r_tvalid & tready & r_teof;

    // State register
    always_ff @(posedge aclk_50MHz or posedge areset_0) begin
        if (areset_0) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and frame launch strobe
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: if (r_ap_start && w_dims_ok) begin
                w_start     = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN:  if (w_last_beat) w_state_nxt = ST_DONE;
            ST_DONE: if (r_auto && w_dims_ok) begin
                w_start     = 1'b1;
                w_state_nxt = ST_RUN;
            end else begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- Pattern generator ----------------
    assign w_adv      = r_gen_busy & (~r_tvalid | tready);
    assign w_x_last   = (r_x == r_w - 13'd1);
    assign w_bw       = r_w >> 3;
    // A zero bar width (W < 8) advances the bar on every pixel
    assign w_bar_wrap = ({1'b0, r_bar_cnt} + 14'd1) >= {1'b0, w_bw};

    // Current input pixel colour
    always_comb begin
        w_pix = 24'd0;
        if (r_pat == 8'd9) begin
            case (r_bar)       // packed {R, B, G}
                3'd0:    w_pix = 24'hFFFFFF;
                3'd1:    w_pix = 24'hFF00FF;
                3'd2:    w_pix = 24'h00FFFF;
                3'd3:    w_pix = 24'h0000FF;
                3'd4:    w_pix = 24'hFFFF00;
                3'd5:    w_pix = 24'hFF0000;
                3'd6:    w_pix = 24'h00FF00;
                default: w_pix = 24'h000000;
            endcase
        end else if (r_pat == 8'd1) begin
            w_pix = {r_x[7:0], r_x[7:0], r_x[7:0]};
        end
    end

`ifdef HSUB_AVG_EN
    function automatic logic [7:0] f_avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
        return s[8:1];
    endfunction
    assign w_pair = {f_avg8(r_hold[23:16], w_pix[23:16]),
                     f_avg8(r_hold[15:8],  w_pix[15:8]),
                     f_avg8(r_hold[7:0],   w_pix[7:0])};
`else
    assign w_pair = r_hold;
`endif

    // Raster scan position, bar tracking and even-pixel hold register
    always_ff @(posedge aclk_50MHz or posedge areset_0) begin
        if (areset_0) begin
            r_h <= 13'd0; r_w <= 13'd0; r_pat <= 8'd0;
            r_x <= 13'd0; r_y <= 13'd0; r_bar_cnt <= 13'd0; r_bar <= 3'd0;
            r_gen_busy <= 1'b0; r_hold <= 24'd0;
        end else if (w_start) begin
            r_h <= r_reg_h; r_w <= r_reg_w; r_pat <= r_reg_pat;
            r_x <= 13'd0; r_y <= 13'd0; r_bar_cnt <= 13'd0; r_bar <= 3'd0;
            r_gen_busy <= 1'b1;
        end else if (w_adv) begin
            if (!r_x[0]) r_hold <= w_pix;
            if (w_x_last) begin
                r_x <= 13'd0; r_bar_cnt <= 13'd0; r_bar <= 3'd0;
                if (r_y == r_h - 13'd1) r_gen_busy <= 1'b0;
                else                    r_y <= r_y + 13'd1;
            end else begin
                r_x <= r_x + 13'd1;
                if (w_bar_wrap) begin
                    r_bar_cnt <= 13'd0;
                    if (r_bar != 3'd7) r_bar <= r_bar + 3'd1;
                end else begin
                    r_bar_cnt <= r_bar_cnt + 13'd1;
                end
            end
        end
    end

    // ---------------- Decimator output register ----------------
    // An output beat is formed on odd x (pair complete) or on a lone final even pixel
    assign w_load = w_adv & (r_x[0] | w_x_last);

    // Stream output stage; holds while stalled
    always_ff @(posedge aclk_50MHz or posedge areset_0) begin
        if (areset_0) begin
            r_tvalid <= 1'b0; r_tuser <= 1'b0; r_tlast <= 1'b0;
            r_teof <= 1'b0; r_tdata <= 24'd0;
        end else if (w_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= r_x[0] ? w_pair : w_pix;
            r_tuser  <= (r_y == 13'd0) && (r_x <= 13'd1);
            r_tlast  <= w_x_last;
            r_teof   <= w_x_last && (r_y == r_h - 13'd1);
        end else if (tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign tvalid = r_tvalid;
    assign tdata  = r_tdata;
    assign tuser  = r_tuser;
    assign tlast  = r_tlast;

endmodule
`default_nettype wire

// File: tb/tb_tpg_hsubsample.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpg_hsubsample
// Brief    : Self-checking bench for tpg_hsubsample (scoreboard of beats).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpg_hsubsample;

    logic        aclk_50MHz = 1'b0;
    logic        areset_0   = 1'b1;
    logic [5:0]  s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = 4'hF;
    logic        s_axi_wvalid = 1'b0, s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready = 1'b1;
    logic [5:0]  s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0, s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid, s_axi_rready = 1'b1;
    logic [23:0] tdata;
    logic        tvalid, tuser, tlast;
    logic        tready = 1'b1;

    int          checks = 0, failures = 0;
    int          sof_cnt = 0, beat_cnt = 0;
    logic [25:0] sb[$];
    logic        stall_prev = 1'b0;
    logic [25:0] stall_val = '0;
    logic        rand_ready = 1'b0;

    tpg_hsubsample dut (
        .aclk_50MHz(aclk_50MHz), .areset_0(areset_0),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .tdata(tdata), .tvalid(tvalid), .tready(tready), .tuser(tuser), .tlast(tlast)
    );

    always #10 aclk_50MHz = ~aclk_50MHz;

    // Downstream ready: constant 1 or random 50% toggling
    always @(posedge aclk_50MHz) begin
        #1;
        tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Reference pixel before decimation, packed {R, B, G}
    function automatic logic [23:0] m_pix(input int x, input int w, input int pat);
        int bw, bi;
        logic [7:0] v;
        if (pat == 9) begin
            bw = w / 8;
            bi = (bw == 0) ? x : x / bw;
            if (bi > 7) bi = 7;
            case (bi)
                0: return 24'hFFFFFF;   // white
                1: return 24'hFF00FF;   // yellow
                2: return 24'h00FFFF;   // cyan
                3: return 24'h0000FF;   // green
                4: return 24'hFFFF00;   // magenta
                5: return 24'hFF0000;   // red
                6: return 24'h00FF00;   // blue
                default: return 24'h000000;
            endcase
        end else if (pat == 1) begin
            v = 8'(x);
            return {v, v, v};
        end
        return 24'h000000;
    endfunction

    function automatic logic [7:0] m_avg(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = (int'(a) + int'(b) + 1) / 2;
        return 8'(s);
    endfunction

    // Queue the expected output beats {tuser, tlast, tdata} of one frame
    task automatic push_frame(input int w, input int h, input int pat);
        logic [23:0] p, q;
        for (int y = 0; y < h; y++) begin
            for (int xe = 0; xe < w; xe += 2) begin
                p = m_pix(xe, w, pat);
`ifdef HSUB_AVG_EN
                if (xe + 1 < w) begin
                    q = m_pix(xe + 1, w, pat);
                    p = {m_avg(p[23:16], q[23:16]), m_avg(p[15:8], q[15:8]), m_avg(p[7:0], q[7:0])};
                end
`else
                q = p;
`endif
                sb.push_back({(y == 0 && xe == 0), (xe + 2 >= w), p});
            end
        end
    endtask

    // Scoreboard pop on accepted beats; stall stability tracking
    always @(negedge aclk_50MHz) begin
        logic [25:0] got, exp;
        got = {tuser, tlast, tdata};
        if (areset_0) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!tvalid || got !== stall_val) begin
                    failures++;
                    $display("FAIL stall_hold got valid=%b beat=%h exp beat=%h", tvalid, got, stall_val);
                end
            end
            if (tvalid && tready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got=%h exp=none", got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL beat_%0d got=%h exp=%h", beat_cnt, got, exp);
                    end
                end
                if (tuser) sof_cnt++;
                beat_cnt++;
            end
            stall_prev = tvalid && !tready;
            stall_val  = got;
        end
    end

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d);
        int n;
        @(posedge aclk_50MHz); #1;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk_50MHz); n++; end while (!s_axi_awready && n < 20);
        if (!s_axi_awready) begin
            checks++; failures++;
            $display("FAIL awready_timeout addr=%h got=0 exp=1", a);
        end
        @(posedge aclk_50MHz); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n = 0;
        do begin @(negedge aclk_50MHz); n++; end while (!s_axi_bvalid && n < 20);
        checks++;
        if (!s_axi_bvalid || s_axi_bresp !== 2'b00) begin
            failures++;
            $display("FAIL bresp addr=%h got valid=%b resp=%b exp valid=1 resp=00", a, s_axi_bvalid, s_axi_bresp);
        end
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
        int n;
        @(posedge aclk_50MHz); #1;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk_50MHz); n++; end while (!s_axi_arready && n < 20);
        if (!s_axi_arready) begin
            checks++; failures++;
            $display("FAIL arready_timeout addr=%h got=0 exp=1", a);
        end
        @(posedge aclk_50MHz); #1;
        s_axi_arvalid = 1'b0;
        n = 0;
        do begin @(negedge aclk_50MHz); n++; end while (!s_axi_rvalid && n < 20);
        d = s_axi_rdata;
        checks++;
        if (!s_axi_rvalid || s_axi_rresp !== 2'b00) begin
            failures++;
            $display("FAIL rresp addr=%h got valid=%b resp=%b exp valid=1 resp=00", a, s_axi_rvalid, s_axi_rresp);
        end
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin @(negedge aclk_50MHz); n++; end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain got remaining=%0d exp=0", sb.size());
        end
    endtask

    task automatic count_tvalid(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge aclk_50MHz);
            if (tvalid) hits++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (5) @(posedge aclk_50MHz);
        #1;
        checks++;
        if ({tvalid, tuser, tlast, s_axi_bvalid, s_axi_rvalid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {tvalid, tuser, tlast, s_axi_bvalid, s_axi_rvalid});
        end
        checks++;
        if (tdata !== 24'h0) begin
            failures++;
            $display("FAIL reset_tdata got=%h exp=000000", tdata);
        end
        areset_0 = 1'b0;
        axi_read(6'h00, d);
        checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL reset_control got=%h exp=4", d); end
    endtask

    task automatic test_invalid_dims();
        logic [31:0] d;
        int hits;
        axi_write(6'h00, 32'h1);            // start with H = W = 0
        count_tvalid(30, hits);
        checks++;
        if (hits !== 0) begin failures++; $display("FAIL zero_dims_tvalid got=%0d exp=0", hits); end
        axi_read(6'h00, d);
        checks++;
        if (d !== 32'h5) begin failures++; $display("FAIL zero_dims_control got=%h exp=5", d); end
        axi_write(6'h18, 32'd4097);          // width over the limit
        axi_write(6'h10, 32'd4);
        count_tvalid(30, hits);
        checks++;
        if (hits !== 0) begin failures++; $display("FAIL over_max_tvalid got=%0d exp=0", hits); end
        axi_read(6'h18, d);
        checks++;
        if (d !== 32'd4097) begin failures++; $display("FAIL readback_w got=%0d exp=4097", d); end
        axi_write(6'h3C, 32'hFFFF_FFFF);     // unmapped write, ignored
        axi_read(6'h24, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", d); end
        axi_write(6'h00, 32'h0);
        axi_read(6'h00, d);
        checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL cleared_start got=%h exp=4", d); end
    endtask

    task automatic test_ramp_single();
        logic [31:0] d;
        int n, hits;
        axi_write(6'h18, 32'd16);
        axi_write(6'h10, 32'd2);
        axi_write(6'h20, 32'd1);
        push_frame(16, 2, 1);
        axi_write(6'h00, 32'h1);
        n = 0;
        do begin @(negedge aclk_50MHz); n++; end while (!tvalid && n < 10);
        checks++;
        if (!tvalid || n > 4) begin
            failures++;
            $display("FAIL first_tvalid_latency got=%0d exp<=4", n);
        end
        wait_drain(500);
        count_tvalid(40, hits);
        checks++;
        if (hits !== 0) begin failures++; $display("FAIL single_shot_extra got=%0d exp=0", hits); end
        axi_read(6'h00, d);
        checks++;
        if (d !== 32'h6) begin failures++; $display("FAIL done_first_read got=%h exp=6", d); end
        axi_read(6'h00, d);
        checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL done_second_read got=%h exp=4", d); end
    endtask

    task automatic test_odd_width();
        logic [31:0] d;
        axi_write(6'h18, 32'd13);            // bar width 1, odd line length
        axi_write(6'h10, 32'd2);
        axi_write(6'h20, 32'd9);
        push_frame(13, 2, 9);
        axi_write(6'h00, 32'h1);
        wait_drain(500);
        axi_read(6'h00, d);
        checks++;
        if (d !== 32'h6) begin failures++; $display("FAIL odd_done got=%h exp=6", d); end
    endtask

    task automatic test_free_running();
        logic [31:0] d;
        int n, hits;
        axi_write(6'h18, 32'd480);
        axi_write(6'h10, 32'd3);
        axi_write(6'h20, 32'd9);
        push_frame(480, 3, 9);
        push_frame(480, 3, 9);
        sof_cnt = 0;
        axi_write(6'h00, 32'h81);
        n = 0;
        while (sof_cnt < 2 && n < 5000) begin @(negedge aclk_50MHz); n++; end
        checks++;
        if (sof_cnt < 2) begin failures++; $display("FAIL restart_sof got=%0d exp=2", sof_cnt); end
        axi_write(6'h00, 32'h0);             // let this frame finish, then idle
        wait_drain(5000);
        count_tvalid(40, hits);
        checks++;
        if (hits !== 0) begin failures++; $display("FAIL stop_after_frame got=%0d exp=0", hits); end
        axi_read(6'h00, d);
        checks++;
        if (d !== 32'h6) begin failures++; $display("FAIL free_run_control got=%h exp=6", d); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] d;
        axi_write(6'h18, 32'd480);
        axi_write(6'h10, 32'd2);
        axi_write(6'h20, 32'd9);
        push_frame(480, 2, 9);
        rand_ready = 1'b1;
        axi_write(6'h00, 32'h1);
        wait_drain(8000);
        rand_ready = 1'b0;
        axi_read(6'h00, d);
        checks++;
        if (d !== 32'h6) begin failures++; $display("FAIL bp_control got=%h exp=6", d); end
    endtask

    task automatic test_reset_mid_line();
        logic [31:0] d;
        int n, hits, start;
        axi_write(6'h18, 32'd480);
        axi_write(6'h10, 32'd3);
        axi_write(6'h20, 32'd1);
        push_frame(480, 3, 1);
        start = beat_cnt;
        axi_write(6'h00, 32'h81);
        n = 0;
        while (beat_cnt < start + 50 && n < 2000) begin @(negedge aclk_50MHz); n++; end
        checks++;
        if (beat_cnt < start + 50) begin failures++; $display("FAIL pre_reset_beats got=%0d exp=50", beat_cnt - start); end
        @(posedge aclk_50MHz); #3;
        areset_0 = 1'b1;
        #1;
        checks++;
        if ({tvalid, tuser, tlast, s_axi_bvalid, s_axi_rvalid} !== 5'b0 || tdata !== 24'h0) begin
            failures++;
            $display("FAIL async_reset got flags=%b tdata=%h exp flags=00000 tdata=000000",
                     {tvalid, tuser, tlast, s_axi_bvalid, s_axi_rvalid}, tdata);
        end
        sb.delete();
        repeat (3) @(posedge aclk_50MHz);
        #2;
        areset_0 = 1'b0;
        axi_read(6'h00, d);
        checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL post_reset_control got=%h exp=4", d); end
        count_tvalid(60, hits);
        checks++;
        if (hits !== 0) begin failures++; $display("FAIL post_reset_output got=%0d exp=0", hits); end
    endtask

    initial begin
        test_reset();
        test_invalid_dims();
        test_ramp_single();
        test_odd_width();
        test_free_running();
        test_back_pressure();
        test_reset_mid_line();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
